multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control unit for the multicycle ARM datapath (shared instr/data memory, one ALU reused for PC+4).
//  Main FSM steps each instruction through fetch/decode/execute/writeback and drives datapath mux selects/enables.
//  Condition unit holds NZCV flags; write enables are gated by the instruction's condition.
//  Sits between instruction register fields and the multicycle datapath; supersedes single-cycle Controller.
// PARAMETERS
//  (none; encodings fixed in arm_pkg)
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  synchronous, active-high
//  op          in   2  instr[27:26]: 00 DP, 01 MEM, 10 B
//  cond        in   4  instr[31:28]
//  funct       in   6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) / L (MEM)
//  rd          in   4  instr[15:12]
//  alu_flags   in   4  {N,Z,C,V} from ALU, current cycle
//  pc_write    out  1  PC register enable
//  adr_src     out  1  mem address: 0=PC, 1=result
//  mem_write   out  1  data memory write enable
//  ir_write    out  1  instruction register enable
//  reg_write   out  1  register file write enable
//  alu_src_a   out  1  0=reg A, 1=PC
//  alu_src_b   out  2  00=reg B(shifted), 01=ext imm, 10=const 4
//  result_src  out  2  00=ALUOut reg, 01=data reg, 10=ALU result direct
//  imm_src     out  2  00=DP imm8, 01=MEM imm12, 10=B imm24
//  reg_src     out  2  [0]=1 read R15 as Rn (B); [1]=1 read Rd as Rm (STR)
//  alu_ctl     out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
//  shift       out  1  1 = MOV (result is shifter output)
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
//  Reset: state<=FETCH, flags<=0000, cond_ex_q<=0; while reset=1 pc/ir/reg/mem writes forced 0,
//   mux outputs take FETCH values.
//  FETCH : adr_src=0, ir_write=1, alu_src_a=1, alu_src_b=10, alu_ctl=00, result_src=10, pc_write=1 -> DECODE.
//  DECODE: alu_src_a=1, alu_src_b=10, alu_ctl=00 (PC+8); cond_ex_q<=cond_ex.
//   op=01->MEMADR; op=00 & I->EXECI; op=00 & !I->EXECR; op=10->BRANCH; op=11->FETCH (illegal, no writes).
//  MEMADR: alu_src_a=0, alu_src_b=01, alu_ctl=00; L=1->MEMRD, L=0->MEMWR.
//  MEMRD : adr_src=1, result_src=00 -> MEMWB.  MEMWB: result_src=01, reg_write=cond_ex_q -> FETCH.
//  MEMWR : adr_src=1, result_src=00, mem_write=cond_ex_q, reg_src[1]=1 -> FETCH.
//  EXECR/EXECI: alu_src_a=0, alu_src_b=00/01, alu_ctl from cmd -> ALUWB.
//  ALUWB : result_src=00, reg_write=cond_ex_q & cmd!=CMP -> FETCH.
//  BRANCH: alu_src_a=0, reg_src[0]=1, alu_src_b=01, result_src=10, pc_write=cond_ex_q -> FETCH.
//  Decode: cmd 0100 ADD->00, 0010 SUB->01, 1010 CMP->01, 0000 AND->10, 1100 ORR->11,
//   1101 MOV->00 + shift=1. Other cmd: alu_ctl=00, reg_write 0.
//  Flags: in EXECR/EXECI when cond_ex_q & (S | cmd=CMP): NZ<=alu_flags[3:2];
//   CV<=alu_flags[1:0] only for ADD/SUB/CMP.
//  cond_ex: ARM table (EQ..LE, 1110 AL=1, 1111=0), evaluated on registered flags only.
//   Sampled in DECODE, so a flag update in EXEC never affects the same instruction.
//  Rd=15 (PC-relative result): in ALUWB/MEMWB with cond_ex_q, pc_write=1 as well as reg_write.
//  imm_src = op in every state; unused outputs 0.
//  Latency (cycles): B 3, STR 4, DP 4, LDR 5; failed condition keeps the same length with no writes.
//  Reset mid-instruction: next cycle is FETCH; no pending write completes.
// STRUCTURE
//  arm_pkg: state_t enum, OP_DP/OP_MEM/OP_B, CMD_* codes, ALU_ADD/SUB/AND/ORR, COND_* codes.
//  Sub-module cond_unit: flags register plus cond_ex evaluation.
//  Parent holds FSM and decode logic.
// TESTING
//  1 ADD AL (op00,cond1110,funct001000) -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 only in ALUWB; alu_ctl=00.
//  2 LDR (op01,funct011001) -> 5 states ending MEMWB; adr_src=1 in MEMRD; result_src=01 and reg_write=1 in MEMWB.
//  3 STR (funct011000) -> MEMWR with mem_write=1, reg_src=10; reg_write stays 0 throughout.
//  4 SUBS flags=0100 then BEQ (cond0000) -> pc_write=1 in BRANCH;
//    CMP alu_flags=0000 then BEQ -> pc_write=0 in BRANCH.
//  5 ORR EQ with Z=0 -> 4 cycles, reg_write=0; MOV -> shift=1; CMP -> no reg_write, flags updated.
//  6 reset asserted in MEMADR -> next state FETCH, flags 0000, no mem_write or reg_write issued.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states, opcode,
// data-processing command, ALU control and condition codes.
package arm_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExecR,
      StExecI,
      StAluWb,
      StBranch
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_B   = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition-code evaluation. cond_ex looks only at the
// registered flags, never at the ALU flags of the current cycle.
module cond_unit
   import arm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic       flag_w_nz,
   input  logic       flag_w_cv,
   output logic       cond_ex
);

   logic [3:0] flags_q;
   logic       n, z, c, v;

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
      end else begin
         if (flag_w_nz) flags_q[3:2] <= alu_flags[3:2];
         if (flag_w_cv) flags_q[1:0] <= alu_flags[1:0];
      end
   end

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, data-processing decode and output
// generation; flags and condition checking live in cond_unit.
module multicycle_controller
   import arm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [3:0] cond,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] alu_flags,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [1:0] alu_ctl,
   output logic       shift
);

   state_t     state_q, state_d, st;
   logic       cond_ex, cond_ex_q;
   logic       i_bit, s_bit;
   logic [3:0] cmd;
   logic [1:0] dp_ctl;
   logic       cmd_valid, cmd_cv, is_mov, is_cmp, in_exec, flag_w;

   assign i_bit  = funct[5];
   assign cmd    = funct[4:1];
   assign s_bit  = funct[0];
   assign is_cmp = (cmd == CMD_CMP);

   always_comb begin
      dp_ctl    = ALU_ADD;
      cmd_valid = 1'b1;
      cmd_cv    = 1'b0;
      is_mov    = 1'b0;
      case (cmd)
         CMD_ADD: begin dp_ctl = ALU_ADD; cmd_cv = 1'b1; end
         CMD_SUB: begin dp_ctl = ALU_SUB; cmd_cv = 1'b1; end
         CMD_CMP: begin dp_ctl = ALU_SUB; cmd_cv = 1'b1; end
         CMD_AND: dp_ctl = ALU_AND;
         CMD_ORR: dp_ctl = ALU_ORR;
         CMD_MOV: begin dp_ctl = ALU_ADD; is_mov = 1'b1; end
         default: cmd_valid = 1'b0;
      endcase
   end

   assign in_exec = ~reset & ((state_q == StExecR) | (state_q == StExecI));
   assign flag_w  = in_exec & cond_ex_q & (s_bit | is_cmp);

   cond_unit u_cond_unit (
      .clk       (clk),
      .reset     (reset),
      .cond      (cond),
      .alu_flags (alu_flags),
      .flag_w_nz (flag_w),
      .flag_w_cv (flag_w & cmd_cv),
      .cond_ex   (cond_ex)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         cond_ex_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StDecode) cond_ex_q <= cond_ex;
      end
   end

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (op)
               OP_MEM:  state_d = StMemAdr;
               OP_DP:   state_d = i_bit ? StExecI : StExecR;
               OP_B:    state_d = StBranch;
               default: state_d = StFetch;
            endcase
         end
         StMemAdr: state_d = s_bit ? StMemRd : StMemWr;
         StMemRd:  state_d = StMemWb;
         StExecR,
         StExecI:  state_d = StAluWb;
         default:  state_d = StFetch;
      endcase
   end

   // During reset the datapath sees FETCH mux settings with every write suppressed.
   assign st = reset ? StFetch : state_q;

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      imm_src    = op;
      reg_src    = 2'b00;
      alu_ctl    = ALU_ADD;
      shift      = 1'b0;
      case (st)
         StFetch: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         StDecode: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemAdr: alu_src_b = 2'b01;
         StMemRd:  adr_src = 1'b1;
         StMemWb: begin
            result_src = 2'b01;
            reg_write  = cond_ex_q;
            pc_write   = cond_ex_q & (rd == 4'd15);
         end
         StMemWr: begin
            adr_src    = 1'b1;
            mem_write  = cond_ex_q;
            reg_src[1] = 1'b1;
         end
         StExecR,
         StExecI: begin
            alu_src_b = (st == StExecI) ? 2'b01 : 2'b00;
            alu_ctl   = dp_ctl;
            shift     = is_mov;
         end
         StAluWb: begin
            reg_write = cond_ex_q & cmd_valid & ~is_cmp;
            pc_write  = cond_ex_q & cmd_valid & ~is_cmp & (rd == 4'd15);
         end
         StBranch: begin
            reg_src[0] = 1'b1;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = cond_ex_q;
         end
         default: ;
      endcase
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle check of the multicycle controller outputs against a table
// of per-state expected vectors, compared through a scoreboard queue.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] op;
   logic [3:0] cond;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, shift;
   logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_ctl;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .cond       (cond),
      .funct      (funct),
      .rd         (rd),
      .alu_flags  (alu_flags),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .imm_src    (imm_src),
      .reg_src    (reg_src),
      .alu_ctl    (alu_ctl),
      .shift      (shift)
   );

   always #5 clk = ~clk;

   // {pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a,
   //  alu_src_b[2], result_src[2], imm_src[2], reg_src[2], alu_ctl[2], shift}
   localparam logic [16:0] B_FETCH = 17'b0_0_0_0_0_1_10_10_00_00_00_0;
   localparam logic [16:0] B_DEC   = 17'b0_0_0_0_0_1_10_00_00_00_00_0;
   localparam logic [16:0] B_MADR  = 17'b0_0_0_0_0_0_01_00_00_00_00_0;
   localparam logic [16:0] B_MRD   = 17'b0_1_0_0_0_0_00_00_00_00_00_0;
   localparam logic [16:0] B_MWB   = 17'b0_0_0_0_0_0_00_01_00_00_00_0;
   localparam logic [16:0] B_MWR   = 17'b0_1_0_0_0_0_00_00_00_10_00_0;
   localparam logic [16:0] B_EXR   = 17'b0_0_0_0_0_0_00_00_00_00_00_0;
   localparam logic [16:0] B_EXI   = 17'b0_0_0_0_0_0_01_00_00_00_00_0;
   localparam logic [16:0] B_AWB   = 17'b0_0_0_0_0_0_00_00_00_00_00_0;
   localparam logic [16:0] B_BR    = 17'b0_0_0_0_0_0_01_10_00_01_00_0;

   typedef struct {
      bit          rst;
      logic [1:0]  op;
      logic [3:0]  cond;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic [3:0]  flags;
      logic [16:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [16:0] exp_q[$];
   logic [1:0]  c_op;
   logic [3:0]  c_cond, c_rd;
   logic [5:0]  c_funct;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic instr(input logic [1:0] o, input logic [3:0] cd, input logic [5:0] f,
                        input logic [3:0] r);
      c_op = o; c_cond = cd; c_funct = f; c_rd = r;
   endtask

   // wr = {pc_write, mem_write, ir_write, reg_write}
   task automatic step(input logic [16:0] base, input logic [3:0] wr,
                       input logic [1:0] ctl = 2'b00, input bit sh = 1'b0,
                       input logic [3:0] fl = 4'b0000, input bit r = 1'b0);
      vec_t v;
      logic [16:0] e;
      e      = base;
      e[16]  = wr[3];
      e[14]  = wr[2];
      e[13]  = wr[1];
      e[12]  = wr[0];
      e[6:5] = c_op;
      e[2:1] = ctl;
      e[0]   = sh;
      v.rst = r; v.op = c_op; v.cond = c_cond; v.funct = c_funct; v.rd = c_rd;
      v.flags = fl; v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      if (n_cmp < vecs.size()) begin
         n_bad++;
         $display("FAIL timeout: only %0d of %0d steps compared", n_cmp, vecs.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      logic [16:0] act, e;

      // dedicated reset-state check
      reset     = 1'b1;
      op        = 2'b00;
      cond      = 4'b1110;
      funct     = 6'b000000;
      rd        = 4'd0;
      alu_flags = 4'b0000;
      @(negedge clk);
      act = {pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, alu_src_b,
             result_src, imm_src, reg_src, alu_ctl, shift};
      n_cmp++;
      if (act !== B_FETCH) begin
         n_bad++;
         $display("FAIL reset: outputs got %b want %b", act, B_FETCH);
      end
      @(posedge clk);
      #1;

      // power-on reset
      instr(2'b00, 4'b1110, 6'b000000, 4'd0);
      step(B_FETCH, 4'b0000, .r(1'b1));
      step(B_FETCH, 4'b0000, .r(1'b1));
      // ADD AL
      instr(2'b00, 4'b1110, 6'b001000, 4'd1);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_EXR, 4'b0000, 2'b00); step(B_AWB, 4'b0001);
      // LDR
      instr(2'b01, 4'b1110, 6'b011001, 4'd2);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000); step(B_MADR, 4'b0000);
      step(B_MRD, 4'b0000); step(B_MWB, 4'b0001);
      // STR
      instr(2'b01, 4'b1110, 6'b011000, 4'd2);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000); step(B_MADR, 4'b0000);
      step(B_MWR, 4'b0100);
      // SUBS giving Z, then BEQ taken
      instr(2'b00, 4'b1110, 6'b000101, 4'd3);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_EXR, 4'b0000, 2'b01, 1'b0, 4'b0100); step(B_AWB, 4'b0001);
      instr(2'b10, 4'b0000, 6'b000000, 4'd0);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000); step(B_BR, 4'b1000);
      // CMP clearing Z, then BEQ not taken
      instr(2'b00, 4'b1110, 6'b010101, 4'd0);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_EXR, 4'b0000, 2'b01, 1'b0, 4'b0000); step(B_AWB, 4'b0000);
      instr(2'b10, 4'b0000, 6'b000000, 4'd0);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000); step(B_BR, 4'b0000);
      // ORR EQ with Z clear: full length, no write
      instr(2'b00, 4'b0000, 6'b011000, 4'd4);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_EXR, 4'b0000, 2'b11); step(B_AWB, 4'b0000);
      // MOV immediate
      instr(2'b00, 4'b1110, 6'b111010, 4'd5);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_EXI, 4'b0000, 2'b00, 1'b1); step(B_AWB, 4'b0001);
      // ADD to R15 also writes PC
      instr(2'b00, 4'b1110, 6'b001000, 4'd15);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_EXR, 4'b0000, 2'b00); step(B_AWB, 4'b1001);
      // CMP setting Z (no register write)
      instr(2'b00, 4'b1110, 6'b010101, 4'd0);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_EXR, 4'b0000, 2'b01, 1'b0, 4'b0100); step(B_AWB, 4'b0000);
      // illegal op returns to FETCH after DECODE
      instr(2'b11, 4'b1110, 6'b000000, 4'd0);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      // LDR interrupted by reset in MEMADR
      instr(2'b01, 4'b1110, 6'b011001, 4'd2);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000);
      step(B_FETCH, 4'b0000, .r(1'b1));
      // flags cleared by reset: BEQ not taken, BNE taken
      instr(2'b10, 4'b0000, 6'b000000, 4'd0);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000); step(B_BR, 4'b0000);
      instr(2'b10, 4'b0001, 6'b000000, 4'd0);
      step(B_FETCH, 4'b1010); step(B_DEC, 4'b0000); step(B_BR, 4'b1000);

      for (int i = 0; i < vecs.size(); i++) begin
         reset     = vecs[i].rst;
         op        = vecs[i].op;
         cond      = vecs[i].cond;
         funct     = vecs[i].funct;
         rd        = vecs[i].rd;
         alu_flags = vecs[i].flags;
         exp_q.push_back(vecs[i].exp);
         @(negedge clk);
         act = {pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, alu_src_b,
                result_src, imm_src, reg_src, alu_ctl, shift};
         e = exp_q.pop_front();
         n_cmp++;
         if (act !== e) begin
            n_bad++;
            $display("FAIL step%0d: outputs got %b want %b", i, act, e);
         end
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
